// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared constants and types for the ADC SPI responder.
// Frame geometry, FSM states and channel/sample types.
package adc_spi_pkg;

    localparam int DATA_W      = 12;
    localparam int N_CH        = 8;
    localparam int CH_W        = $clog2(N_CH);
    localparam int SYNC_STAGES = 2;
    localparam int LEAD_ZEROS  = 4;
    localparam int WORD_W      = LEAD_ZEROS + DATA_W;

    typedef logic [4:0]        cnt_t;
    typedef logic [CH_W-1:0]   ch_t;
    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam cnt_t FRAME_BITS      = 5'd16;
    localparam cnt_t ADDR_FIRST_EDGE = 5'd3;
    localparam cnt_t ADDR_LAST_EDGE  = 5'd5;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an asynchronous pin
// followed by one history flop producing single-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              sync_s;

    assign sync_s = sync_q[STAGES-1];

    // Shift the pin through the synchronizer and remember the last value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_s;
        end
    end

    assign rise_o = sync_s & ~prev_q;
    assign fall_o = ~sync_s & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: on-chip stand-in for an 8-channel 12-bit SPI ADC.
// Define ADC_RESP_AUTOINC_EN to ramp each channel after it is read.
module adc_spi_responder
    import adc_spi_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCS_n,
    input  logic              iSCLK,
    input  logic              iDIN,
    output logic              oDOUT,
    output logic              oDOUT_EN,
    input  logic              iWR_EN,
    input  logic [CH_W-1:0]   iWR_CH,
    input  logic [DATA_W-1:0] iWR_DATA,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic [CH_W-1:0]   oLAST_CH
);

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic din_s;

    state_e  state_q, state_d;
    cnt_t    cnt_q, cnt_d;
    word_t   word_q, word_d;
    ch_t     new_addr_q, new_addr_d;
    ch_t     pend_q, pend_d;
    ch_t     last_q, last_d;
    logic    done_q, done_d;
    sample_t regs_q [N_CH];

    // Both master strobes idle high, so their synchronizers reset high.
    sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_det (
        .clk_i  (iCLK),
        .rst_i  (iRST),
        .d_i    (iCS_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sclk_det (
        .clk_i  (iCLK),
        .rst_i  (iRST),
        .d_i    (iSCLK),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // DIN needs no edge detect, only the same synchronizer depth.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            din_sync_q <= '0;
        end else begin
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], iDIN};
        end
    end

    assign din_s = din_sync_q[SYNC_STAGES-1];

    // FSM and frame datapath registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            new_addr_q <= '0;
            pend_q     <= '0;
            last_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            new_addr_q <= new_addr_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    // Next state: CS_n edges dominate SCLK edges in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        new_addr_d = new_addr_q;
        pend_d     = pend_q;
        last_d     = last_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    word_d  = {{LEAD_ZEROS{1'b0}}, regs_q[pend_q]};
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    if (cnt_q < FRAME_BITS) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_d >= ADDR_FIRST_EDGE &&
                            cnt_d <= ADDR_LAST_EDGE) begin
                            new_addr_d = {new_addr_q[CH_W-2:0], din_s};
                        end
                        if (cnt_d == FRAME_BITS) begin
                            done_d = 1'b1;
                            pend_d = new_addr_d;
                            last_d = new_addr_d;
                        end
                    end
                end else if (sclk_fall) begin
                    // First fall of a frame keeps the MSB already driven.
                    if (cnt_q == FRAME_BITS) begin
                        cnt_d  = '0;
                        word_d = {{LEAD_ZEROS{1'b0}}, regs_q[pend_q]};
                    end else if (cnt_q != '0) begin
                        word_d = {word_q[WORD_W-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    // Channel register file; an explicit write beats the ramp increment.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < N_CH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
`ifdef ADC_RESP_AUTOINC_EN
            // pend_q still names the channel sent in the closing frame.
            if (done_d) begin
                regs_q[pend_q] <= regs_q[pend_q] + sample_t'(1);
            end
`endif
            if (iWR_EN) begin
                regs_q[iWR_CH] <= iWR_DATA;
            end
        end
    end

    assign oDOUT       = (state_q == SHIFT) & word_q[WORD_W-1];
    assign oDOUT_EN    = (state_q == SHIFT);
    assign oBUSY       = (state_q == SHIFT);
    assign oFRAME_DONE = done_q;
    assign oLAST_CH    = last_q;

endmodule
